// File: rtl/uart_cmd_hub_pkg.sv
// Shared constants and TX FSM state encoding for uart_cmd_hub.
// ACK byte replacement is enabled with the UART_CMD_HUB_ACK_EN macro.
package uart_cmd_hub_pkg;

  localparam logic [7:0] CMD_LED_BASE = 8'h31;
  localparam logic [7:0] CMD_CLR      = 8'h63;
  localparam logic [7:0] ACK_OK       = 8'h4B;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSend  = 2'd1,
    StWait  = 2'd2,
    StDrain = 2'd3
  } tx_state_e;

  // Command byte that toggles LED number idx.
  function automatic logic [7:0] led_cmd_byte(input int unsigned idx);
    return CMD_LED_BASE + 8'(idx);
  endfunction

endpackage

// File: rtl/uart_hub_fifo.sv
// Synchronous byte FIFO for one hub channel; pointers wrap, count is one bit wider.
// Caller must not push when full or pop when empty.
module uart_hub_fifo #(
  parameter int unsigned Depth = 16,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  logic [7:0]      mem [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign dout  = mem[rd_ptr_q];
  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uart_cmd_hub.sv
// Multi-channel UART echo hub with LED command decode on one channel.
// Define UART_CMD_HUB_ACK_EN to echo LED state / 'K' in place of command bytes.
module uart_cmd_hub
  import uart_cmd_hub_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned LEDS        = 4,
  parameter int unsigned CMD_CHANNEL = 0,
  parameter int unsigned HB_BITS     = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   rx_valid,
  input  logic [8*CHANNELS-1:0] rx_data,
  input  logic [CHANNELS-1:0]   tx_busy,
  output logic [CHANNELS-1:0]   tx_send,
  output logic [8*CHANNELS-1:0] tx_data,
  output logic [LEDS-1:0]       led,
  output logic                  heartbeat,
  output logic [CHANNELS-1:0]   overflow
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [HB_BITS-1:0]  hb_q;
  logic [LEDS-1:0]     led_q, led_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic [CHANNELS-1:0] drop;
  logic [7:0]          cmd_byte;
  logic                cmd_valid;

  assign cmd_byte  = rx_data[8*CMD_CHANNEL +: 8];
  assign cmd_valid = rx_valid[CMD_CHANNEL];

  // Decode acts on every command-channel byte, whether or not the FIFO took it.
  always_comb begin
    led_d = led_q;
    for (int unsigned j = 0; j < LEDS; j++) begin
      if (cmd_valid && cmd_byte == led_cmd_byte(j)) led_d[j] = ~led_q[j];
    end
    ovf_d = (cmd_valid && cmd_byte == CMD_CLR) ? '0 : ovf_q;
    ovf_d = ovf_d | drop;
  end

`ifdef UART_CMD_HUB_ACK_EN
  logic [7:0] ack_byte;

  always_comb begin
    ack_byte = cmd_byte;
    for (int unsigned j = 0; j < LEDS; j++) begin
      if (cmd_byte == led_cmd_byte(j)) ack_byte = ASCII_ZERO | {7'd0, ~led_q[j]};
    end
    if (cmd_byte == CMD_CLR) ack_byte = ACK_OK;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_q  <= '0;
      led_q <= '0;
      ovf_q <= '0;
    end else begin
      hb_q  <= hb_q + 1'b1;
      led_q <= led_d;
      ovf_q <= ovf_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    tx_state_e       state_q;
    logic            send_q;
    logic [7:0]      data_q;
    logic [7:0]      fifo_din, fifo_dout;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CntW-1:0] fifo_count;

`ifdef UART_CMD_HUB_ACK_EN
    if (g == CMD_CHANNEL) begin : g_ack
      assign fifo_din = ack_byte;
    end else begin : g_raw
      assign fifo_din = rx_data[8*g +: 8];
    end
`else
    assign fifo_din = rx_data[8*g +: 8];
`endif

    // Full is judged on the registered count, so a same-cycle pop does not save the byte.
    assign fifo_push = rx_valid[g] && (fifo_count < CntW'(FIFO_DEPTH));
    assign drop[g]   = rx_valid[g] && fifo_full;
    assign fifo_pop  = (state_q == StIdle) && !fifo_empty && !tx_busy[g];

    uart_hub_fifo #(
      .Depth(FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (fifo_push),
      .pop  (fifo_pop),
      .din  (fifo_din),
      .dout (fifo_dout),
      .full (fifo_full),
      .empty(fifo_empty),
      .count(fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= StIdle;
        send_q  <= 1'b0;
        data_q  <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (fifo_pop) begin
              state_q <= StSend;
              send_q  <= 1'b1;
              data_q  <= fifo_dout;
            end
          end
          StSend: begin
            state_q <= StWait;
            send_q  <= 1'b0;
          end
          StWait: begin
            if (tx_busy[g]) state_q <= StDrain;
          end
          StDrain: begin
            if (!tx_busy[g]) state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
            send_q  <= 1'b0;
          end
        endcase
      end
    end

    assign tx_send[g]        = send_q;
    assign tx_data[8*g +: 8] = data_q;
  end

  assign led       = led_q;
  assign overflow  = ovf_q;
  assign heartbeat = hb_q[HB_BITS-1];

endmodule

// File: tb/tb_uart_cmd_hub.sv
// Directed self-checking bench for uart_cmd_hub with a 3-cycle-busy uart stub per channel.
module tb_uart_cmd_hub;

  localparam int unsigned CH   = 2;
  localparam int unsigned LEDS = 4;
  localparam int unsigned HBB  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [CH-1:0]     rx_valid = '0;
  logic [8*CH-1:0]   rx_data = '0;
  logic [CH-1:0]     tx_busy;
  logic [CH-1:0]     tx_send;
  logic [8*CH-1:0]   tx_data;
  logic [LEDS-1:0]   led;
  logic              heartbeat;
  logic [CH-1:0]     overflow;

  int checks = 0;
  int failures = 0;
  logic [CH-1:0] hold = '0;
  int busy_cnt [CH];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] exp3 [4];
  logic [7:0] exp5;
  int n_before;

  always #5 clk = ~clk;

  uart_cmd_hub #(
    .CHANNELS   (CH),
    .FIFO_DEPTH (16),
    .LEDS       (LEDS),
    .CMD_CHANNEL(0),
    .HB_BITS    (HBB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_busy  (tx_busy),
    .tx_send  (tx_send),
    .tx_data  (tx_data),
    .led      (led),
    .heartbeat(heartbeat),
    .overflow (overflow)
  );

  // Uart stub: busy for 3 cycles after each accepted strobe, or while held.
  always @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (tx_send[i] === 1'b1) busy_cnt[i] <= 3;
      else if (busy_cnt[i] > 0) busy_cnt[i] <= busy_cnt[i] - 1;
    end
  end

  always_comb begin
    tx_busy = '0;
    for (int i = 0; i < CH; i++) tx_busy[i] = hold[i] || (busy_cnt[i] != 0);
  end

  always @(negedge clk) begin
    if (tx_send[0] === 1'b1) q0.push_back(tx_data[7:0]);
    if (tx_send[1] === 1'b1) q1.push_back(tx_data[15:8]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int ch, input logic [7:0] b);
    @(negedge clk);
    rx_valid[ch] = 1'b1;
    rx_data[8*ch +: 8] = b;
    @(negedge clk);
    rx_valid[ch] = 1'b0;
  endtask

  task automatic burst0(input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rx_valid[0] = 1'b1;
      rx_data[7:0] = first + 8'(k);
    end
    @(negedge clk);
    rx_valid[0] = 1'b0;
  endtask

  initial begin
`ifdef UART_CMD_HUB_ACK_EN
    exp3 = '{8'h31, 8'h31, 8'h30, 8'h35};
    exp5 = 8'h4B;
`else
    exp3 = '{8'h31, 8'h33, 8'h31, 8'h35};
    exp5 = 8'h63;
`endif

    // Reset state and heartbeat
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_send", 32'(tx_send), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_led", 32'(led), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_heartbeat", 32'(heartbeat), 32'h0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("hb_after_8", 32'(heartbeat), 32'h1);
    repeat (8) @(posedge clk);
    #1 check("hb_wrap_16", 32'(heartbeat), 32'h0);

    // 1: single byte on ch1, 2-cycle latency, one-cycle strobe
    send(1, 8'h41);
    check("t1_no_send_yet", 32'(tx_send), 32'h0);
    @(negedge clk);
    check("t1_send_strobe", 32'(tx_send), 32'h2);
    check("t1_tx_data", 32'(tx_data[15:8]), 32'h41);
    @(negedge clk);
    check("t1_strobe_len", 32'(tx_send), 32'h0);
    repeat (20) @(negedge clk);
    check("t1_ch1_count", 32'(q1.size()), 32'd1);
    check("t1_ch1_byte", 32'(q1[0]), 32'h41);
    check("t1_ch0_count", 32'(q0.size()), 32'd0);

    // 2: 20-byte burst into busy ch0 overflows, then 16 drain in order
    hold[0] = 1'b1;
    burst0(8'h00, 20);
    check("t2_overflow", 32'(overflow), 32'h1);
    repeat (5) @(negedge clk);
    check("t2_held_no_tx", 32'(q0.size()), 32'd0);
    hold[0] = 1'b0;
    for (int c = 0; c < 600 && q0.size() < 16; c++) @(negedge clk);
    repeat (30) @(negedge clk);
    check("t2_tx_count", 32'(q0.size()), 32'd16);
    for (int k = 0; k < 16; k++) check($sformatf("t2_byte%0d", k), 32'(q0[k]), 32'(k));

    // 3: LED commands on ch0
    q0.delete();
    send(0, 8'h31);
    check("t3_led_a", 32'(led), 32'h1);
    send(0, 8'h33);
    check("t3_led_b", 32'(led), 32'h5);
    send(0, 8'h31);
    check("t3_led_c", 32'(led), 32'h4);
    send(0, 8'h35);
    check("t3_led_out_of_range", 32'(led), 32'h4);
    repeat (60) @(negedge clk);
    check("t3_echo_count", 32'(q0.size()), 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("t3_echo%0d", k), 32'(q0[k]), 32'(exp3[k]));
    check("t3_overflow_sticky", 32'(overflow), 32'h1);

    // 4: same bytes on ch1 do nothing but echo
    q1.delete();
    send(1, 8'h31);
    send(1, 8'h33);
    send(1, 8'h31);
    send(1, 8'h35);
    check("t4_led_unchanged", 32'(led), 32'h4);
    repeat (60) @(negedge clk);
    check("t4_echo_count", 32'(q1.size()), 32'd4);
    check("t4_echo0", 32'(q1[0]), 32'h31);
    check("t4_echo1", 32'(q1[1]), 32'h33);
    check("t4_echo2", 32'(q1[2]), 32'h31);
    check("t4_echo3", 32'(q1[3]), 32'h35);
    check("t4_overflow_kept", 32'(overflow), 32'h1);

    // 5: clear command
    q0.delete();
    send(0, 8'h63);
    check("t5_overflow_clr", 32'(overflow), 32'h0);
    repeat (20) @(negedge clk);
    check("t5_echo_count", 32'(q0.size()), 32'd1);
    check("t5_echo", 32'(q0[0]), 32'(exp5));

    // 6: reset while ch0 sits in DRAIN with 5 bytes queued
    q0.delete();
    burst0(8'h50, 6);
    hold[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_first_sent", 32'(q0.size()), 32'd1);
    check("t6_led_before", 32'(led), 32'h4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_tx_send", 32'(tx_send), 32'h0);
    check("t6_rst_tx_data", 32'(tx_data), 32'h0);
    check("t6_rst_led", 32'(led), 32'h0);
    check("t6_rst_overflow", 32'(overflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    hold[0] = 1'b0;
    n_before = q0.size();
    repeat (40) @(negedge clk);
    check("t6_no_tx_after", 32'(q0.size()), 32'(n_before));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
